// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC register, word-aligned fetch address and IF/ID pipeline register.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 128
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    input  logic [31:0] Instruction,
    output logic [31:0] IMemAddress,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic [31:0] FetchCount
);
    localparam int AW = $clog2(IMEM_WORDS) + 2;
    logic [31:0]   pc;
    logic [AW-1:0] pc_lo_inc;
    logic [31:0]   next_pc;
    // Increment wraps inside the instruction space; bits above it are left alone.
    assign pc_lo_inc   = pc[AW-1:0] + AW'(4);
    assign next_pc     = {pc[31:AW], pc_lo_inc};
    assign IMemAddress = pc;
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc               <= RESET_PC;
            IFID_Instruction <= '0;
            IFID_PCPlus4     <= '0;
            IFID_Valid       <= 1'b0;
            FetchCount       <= '0;
        end else if (Redirect) begin
            pc               <= {RedirectTarget[31:2], 2'b00};
            IFID_Instruction <= '0;
            IFID_PCPlus4     <= '0;
            IFID_Valid       <= 1'b0;
        end else if (!Stall) begin
            pc               <= next_pc;
            IFID_Instruction <= Instruction;
            IFID_PCPlus4     <= pc + 32'd4;
            IFID_Valid       <= 1'b1;
            FetchCount       <= FetchCount + 32'd1;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scoreboard bench for the fetch unit with a modelled instruction memory.
module tb_instruction_fetch_unit;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectTarget = '0;
    logic [31:0] Instruction;
    logic [31:0] IMemAddress;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic [31:0] FetchCount;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] p4;
        logic [31:0] cnt;
        logic        v;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          errors = 0;
    logic [31:0] m_pc, m_ins, m_p4, m_cnt;
    logic        m_v;
    bit          m_init = 0;

    instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(128)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Redirect(Redirect),
        .RedirectTarget(RedirectTarget), .Instruction(Instruction),
        .IMemAddress(IMemAddress), .IFID_Instruction(IFID_Instruction),
        .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid), .FetchCount(FetchCount)
    );

    always #5 Clk = ~Clk;

    // Memory word i holds i*4 over a 128-word space.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return {23'b0, a[8:2], 2'b00};
    endfunction

    assign Instruction = memword(IMemAddress);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst_n, input logic st, input logic rd, input logic [31:0] tgt);
        exp_t e;
        @(negedge Clk);
        Reset = rst_n;
        Stall = st;
        Redirect = rd;
        RedirectTarget = tgt;
        if (m_init) chk("imem_addr_pre", IMemAddress, m_pc);
        if (!rst_n) begin
            m_pc = 32'h0; m_ins = 0; m_p4 = 0; m_v = 0; m_cnt = 0;
            m_init = 1;
        end else if (rd) begin
            m_pc = {tgt[31:2], 2'b00}; m_ins = 0; m_p4 = 0; m_v = 0;
        end else if (!st) begin
            m_ins = memword(m_pc);
            m_p4 = m_pc + 32'd4;
            m_pc = {m_pc[31:9], m_pc[8:0] + 9'd4};
            m_v = 1;
            m_cnt = m_cnt + 1;
        end
        e.pc = m_pc; e.ins = m_ins; e.p4 = m_p4; e.cnt = m_cnt; e.v = m_v;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        chk("pc", IMemAddress, e.pc);
        chk("ifid_instr", IFID_Instruction, e.ins);
        chk("ifid_pcplus4", IFID_PCPlus4, e.p4);
        chk("ifid_valid", {31'b0, IFID_Valid}, {31'b0, e.v});
        chk("fetch_count", FetchCount, e.cnt);
    endtask

    initial begin
        step(0, 0, 0, 0);
        step(0, 1, 1, 32'h80);
        chk("reset_valid", {31'b0, IFID_Valid}, 32'h0);
        chk("reset_pc", IMemAddress, 32'h0);
        repeat (4) step(1, 0, 0, 0);
        chk("run4_instr", IFID_Instruction, 32'd12);
        chk("run4_p4", IFID_PCPlus4, 32'd16);
        chk("run4_count", FetchCount, 32'd4);

        step(0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0);
        chk("stall_pc", IMemAddress, 32'h8);
        chk("stall_instr", IFID_Instruction, 32'd4);
        chk("stall_p4", IFID_PCPlus4, 32'd8);
        chk("stall_count", FetchCount, 32'd2);
        step(1, 0, 0, 0);
        chk("release_instr", IFID_Instruction, 32'd8);
        step(1, 0, 0, 0);
        chk("pre_redirect_pc", IMemAddress, 32'h10);

        step(1, 0, 1, 32'h41);
        chk("redir_pc", IMemAddress, 32'h40);
        chk("redir_valid", {31'b0, IFID_Valid}, 32'h0);
        step(1, 0, 0, 0);
        chk("redir_target_instr", IFID_Instruction, 32'd64);
        chk("redir_target_p4", IFID_PCPlus4, 32'h44);

        step(1, 1, 1, 32'h100);
        chk("redir_stall_pc", IMemAddress, 32'h100);
        chk("redir_stall_instr", IFID_Instruction, 32'h0);

        step(1, 0, 1, 32'h1FC);
        step(1, 0, 0, 0);
        chk("wrap_pc", IMemAddress, 32'h0);
        chk("wrap_p4", IFID_PCPlus4, 32'h200);

        step(1, 0, 1, 32'h1000_01FE);
        chk("far_pc", IMemAddress, 32'h1000_01FC);
        step(1, 0, 0, 0);
        chk("far_wrap_pc", IMemAddress, 32'h1000_0000);
        step(1, 0, 0, 0);

        step(1, 0, 1, 32'h30);
        step(0, 0, 1, 32'h80);
        chk("midreset_pc", IMemAddress, 32'h0);
        chk("midreset_count", FetchCount, 32'h0);
        step(1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Requester-side counterpart to the instruction memory: owns the program counter, drives the word-aligned fetch address into the instruction memory, samples the returned instruction in the same cycle and registers it into the IF/ID pipeline register. Sits at the front of the MIPS pipeline. It accepts stall and redirect (branch/jump) requests from later stages and maintains a retired-fetch counter for debug.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- IMEM_WORDS, 128: instruction memory depth in words, a power of two; sets the PC wrap boundary.
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  reset; synchronous and active-low.
- Stall  input  1  hold PC and IF/ID contents this cycle.
- Redirect  input  1  load PC from RedirectTarget and squash the instruction being fetched.
- RedirectTarget  input  32  byte address of the redirect destination.
- Instruction  input  32  word returned combinationally by the instruction memory for IMemAddress.
- IMemAddress  output  32  fetch byte address, equal to PC; the memory ignores bits [1:0].
- IFID_Instruction  output  32  registered instruction; 0 (NOP) when invalid.
- IFID_PCPlus4  output  32  registered PC+4 of that instruction.
- IFID_Valid  output  1  IF/ID holds a real instruction.
- FetchCount  output  32  number of instructions accepted into IF/ID since reset.

## Operation
- One register PC; IMemAddress = PC, purely combinational from the register.
- Reset value for Reset=0 at an edge: PC=RESET_PC, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, FetchCount=0.
- Priority at each edge: reset > Redirect > Stall > normal fetch.
- Normal fetch (Redirect=0, Stall=0):
  - PC <= next PC
  - IFID_Instruction <= Instruction
  - IFID_PCPlus4 <= PC+4
  - IFID_Valid <= 1
  - FetchCount <= FetchCount+1
- Stall (Redirect=0, Stall=1): PC, IF/ID and FetchCount all hold their values.
- Redirect=1, regardless of Stall:
  - PC <= {RedirectTarget[31:2], 2'b00}; bits [1:0] are forced to zero.
  - IF/ID squashed: IFID_Instruction <= 0, IFID_PCPlus4 <= 0, IFID_Valid <= 0.
  - FetchCount holds.
- Next PC = PC+4, wrapped within the instruction space: bits [log2(IMEM_WORDS)+1:0] increment modulo IMEM_WORDS*4; upper bits hold. With the defaults, PC 0x1FC goes to 0x000.
- Redirect targets outside the instruction space are loaded unmodified. The wrap applies only on the subsequent increment.
- FetchCount wraps modulo 2^32.
- The block has no state machine beyond the PC, the IF/ID register and the counter. Everything is registered; the only combinational output is IMemAddress.

## Timing
- Fetch latency is one cycle: the instruction at PC appears on IFID_Instruction after the edge that ends the cycle in which PC was presented.
- Instruction must be stable before the edge while PC is held. The block imposes no wait states.
- First valid IF/ID is at the first edge after Reset deasserts. IFID_Valid rises there with IFID_PCPlus4 = RESET_PC+4.
- Redirect penalty: the bubble lands in IF/ID at the redirect edge. The target instruction is in IF/ID one edge later.
- Stall held for N edges: IF/ID unchanged for N edges, then resumes with the same PC.
- Reset asserted mid-stream: all state returns to reset values at that edge, overriding a simultaneous Redirect or Stall.
- Redirect and Stall in the same cycle: redirect taken and IF/ID squashed. The stall is not honoured for that edge.

## Test plan
- Reset, then 4 free-run cycles with memory word i = i*4 -> IFID_Instruction 0,4,8,12; IFID_PCPlus4 4,8,12,16; FetchCount 4.
- Stall high for 3 edges at PC=0x8 -> IMemAddress stays 0x8; IF/ID holds (Instruction=4, PCPlus4=8); FetchCount unchanged; fetch of 0x8 follows on release.
- Redirect to 0x41 at PC=0x10 -> next edge PC=0x40 and IFID_Valid=0 with Instruction=0; following edge IFID_Instruction=memory[16], PCPlus4=0x44.
- Redirect and Stall together -> redirect wins: PC=target, bubble in IF/ID.
- Free-run from PC=0x1FC with IMEM_WORDS=128 -> next PC=0x000; IFID_PCPlus4=0x200.
- Reset pulled low for one edge during a redirect at PC=0x30 -> PC=RESET_PC, IFID_Valid=0, FetchCount=0.
